// File: rtl/pbs_battle_core_if.sv
// rtl/pbs_battle_core_if.sv - control and status bundle between the battle FSM and the battle datapath
interface pbs_battle_core_if;
  logic       target;
  logic [1:0] p_move;
  logic       actr;
  logic       calc_dmg;
  logic       app_dmg;
  logic [3:0] p_hp;
  logic [3:0] AI_hp;
  logic [3:0] new_hp;
  logic [1:0] last_move;
  logic       last_hit;
  logic [5:0] rnd;

  modport master (
    output target, p_move, actr, calc_dmg, app_dmg,
    input  p_hp, AI_hp, new_hp, last_move, last_hit, rnd
  );

  modport slave (
    input  target, p_move, actr, calc_dmg, app_dmg,
    output p_hp, AI_hp, new_hp, last_move, last_hit, rnd
  );
endinterface

// File: rtl/pbs_battle_core.sv
// rtl/pbs_battle_core.sv - battle datapath: hit points, move select, LFSR, hit roll and saturating damage
module pbs_battle_core #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input logic              clk,
  input logic              rst,
  pbs_battle_core_if.slave bus
);

  // An all-zero LFSR would lock up, so a zero seed is promoted to 1.
  localparam logic [15:0] SEED_NZ = (SEED == 16'h0000) ? 16'h0001 : SEED;

  logic [15:0] lfsr;
  logic        lfsr_fb;
  logic [1:0]  rng_ai;
  logic [3:0]  rng_acc;
  logic [1:0]  mv;
  logic [3:0]  mv_dmg;
  logic [3:0]  mv_acc;
  logic [3:0]  curr_hp;
  logic [3:0]  dmg;
  logic [3:0]  p_hp;
  logic [3:0]  ai_hp;
  logic [3:0]  new_hp;
  logic [1:0]  last_move;
  logic        last_hit;

  assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign rng_ai  = lfsr[1:0];
  assign rng_acc = lfsr[5:2];
  assign mv      = bus.actr ? rng_ai : bus.p_move;

  // Move table: damage and accuracy per move index.
  always_comb begin
    mv_dmg = 4'd2;
    mv_acc = 4'd15;
    case (mv)
      2'd0: begin mv_dmg = 4'd2; mv_acc = 4'd15; end
      2'd1: begin mv_dmg = 4'd4; mv_acc = 4'd12; end
      2'd2: begin mv_dmg = 4'd6; mv_acc = 4'd8;  end
      2'd3: begin mv_dmg = 4'd9; mv_acc = 4'd4;  end
      default: begin mv_dmg = 4'd2; mv_acc = 4'd15; end
    endcase
  end

  // Free-running Fibonacci LFSR, advancing every cycle out of reset.
  always_ff @(posedge clk) begin
    if (!rst) lfsr <= SEED_NZ;
    else      lfsr <= {lfsr[14:0], lfsr_fb};
  end

  // Stage 1: latch move, damage, defender HP and hit roll on calc_dmg.
  always_ff @(posedge clk) begin
    if (!rst) begin
      last_move <= 2'd0;
      dmg       <= 4'd0;
      curr_hp   <= 4'd0;
      last_hit  <= 1'b0;
    end else if (bus.calc_dmg) begin
      last_move <= mv;
      dmg       <= mv_dmg;
      curr_hp   <= bus.target ? ai_hp : p_hp;
      last_hit  <= (mv_acc >= rng_acc);
    end
  end

  // Stage 2: saturating subtract, recomputed every cycle from the stage-1 latches.
  always_ff @(posedge clk) begin
    if (!rst)          new_hp <= 4'd0;
    else if (!last_hit) new_hp <= curr_hp;
    else if (curr_hp > dmg) new_hp <= curr_hp - dmg;
    else               new_hp <= 4'd0;
  end

  // Apply: write the pending HP into the defender selected at apply time.
  always_ff @(posedge clk) begin
    if (!rst) begin
      p_hp  <= 4'd15;
      ai_hp <= 4'd15;
    end else if (bus.app_dmg) begin
      if (bus.target) ai_hp <= new_hp;
      else            p_hp  <= new_hp;
    end
  end

  assign bus.p_hp      = p_hp;
  assign bus.AI_hp     = ai_hp;
  assign bus.new_hp    = new_hp;
  assign bus.last_move = last_move;
  assign bus.last_hit  = last_hit;
  assign bus.rnd       = lfsr[5:0];

endmodule

// File: tb/tb_pbs_battle_core.sv
// tb/tb_pbs_battle_core.sv - self-checking bench for pbs_battle_core against a behavioural battle model
module tb_pbs_battle_core;

  localparam logic [15:0] SEED = 16'hACE1;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  pbs_battle_core_if bus ();

  pbs_battle_core #(.SEED(SEED)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: battle quantities as plain integers.
  int dmg_tab [4] = '{2, 4, 6, 9};
  int acc_tab [4] = '{15, 12, 8, 4};
  int m_lfsr;
  int m_hp [2];
  int m_new;
  int m_cur;
  int m_dmg;
  int m_move;
  int m_hit;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int lfsr_next(input int l);
    int fb;
    fb = ((l >> 15) ^ (l >> 13) ^ (l >> 12) ^ (l >> 10)) & 1;
    return ((l << 1) | fb) & 16'hFFFF;
  endfunction

  task automatic model_step();
    int mv;
    int nxt_new;
    int old_hp [2];
    if (!rst) begin
      m_lfsr = (SEED == 0) ? 1 : int'(SEED);
      m_hp[0] = 15; m_hp[1] = 15;
      m_new = 0; m_cur = 0; m_dmg = 0; m_move = 0; m_hit = 0;
      return;
    end
    old_hp = m_hp;
    mv = bus.actr ? (m_lfsr & 3) : int'(bus.p_move);
    nxt_new = m_hit ? ((m_cur > m_dmg) ? m_cur - m_dmg : 0) : m_cur;
    if (bus.app_dmg) m_hp[bus.target] = m_new;
    if (bus.calc_dmg) begin
      m_move = mv;
      m_dmg  = dmg_tab[mv];
      m_cur  = old_hp[bus.target];
      m_hit  = (acc_tab[mv] >= ((m_lfsr >> 2) & 15)) ? 1 : 0;
    end
    m_new  = nxt_new;
    m_lfsr = lfsr_next(m_lfsr);
  endtask

  task automatic compare_all();
    chk("p_hp", bus.p_hp, m_hp[0]);
    chk("AI_hp", bus.AI_hp, m_hp[1]);
    chk("new_hp", bus.new_hp, m_new);
    chk("last_move", bus.last_move, m_move);
    chk("last_hit", bus.last_hit, m_hit);
    chk("rnd", bus.rnd, m_lfsr & 63);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic step(input logic t, input logic a, input logic [1:0] m, input logic c, input logic p);
    bus.target = t; bus.actr = a; bus.p_move = m; bus.calc_dmg = c; bus.app_dmg = p;
    tick();
    bus.calc_dmg = 1'b0; bus.app_dmg = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step(1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    rst = 1'b1;
  endtask

  initial begin
    int roll;
    int exp_hit;
    int exp_mv;
    n_checks = 0;
    n_errors = 0;
    rst = 1'b0;
    bus.target = 1'b0; bus.actr = 1'b0; bus.p_move = 2'd0;
    bus.calc_dmg = 1'b0; bus.app_dmg = 1'b0;

    do_reset();
    chk("rst_p_hp", bus.p_hp, 15);
    chk("rst_ai_hp", bus.AI_hp, 15);
    chk("rst_new_hp", bus.new_hp, 0);
    chk("rst_rnd", bus.rnd, 6'h21);

    // Move 0 on the AI.
    step(1'b1, 1'b0, 2'd0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
    chk("m0_hit", bus.last_hit, 1);
    chk("m0_new_hp", bus.new_hp, 13);
    step(1'b1, 1'b0, 2'd0, 1'b0, 1'b1);
    chk("m0_ai_hp", bus.AI_hp, 13);
    chk("m0_p_hp", bus.p_hp, 15);

    // Player worn down to zero and held there.
    for (int k = 1; k <= 9; k++) begin
      step(1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
      chk("sat_p_hp", bus.p_hp, (15 - 2 * k > 0) ? 15 - 2 * k : 0);
    end

    // Move 3 against a fresh AI: hit iff the roll is at most 4.
    for (int k = 0; k < 8; k++) begin
      do_reset();
      repeat ($urandom_range(0, 7)) step(1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
      roll = (m_lfsr >> 2) & 15;
      exp_hit = (roll <= 4) ? 1 : 0;
      step(1'b1, 1'b0, 2'd3, 1'b1, 1'b0);
      chk("m3_hit", bus.last_hit, exp_hit);
      step(1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 2'd0, 1'b0, 1'b1);
      chk("m3_ai_hp", bus.AI_hp, exp_hit ? 6 : 15);
    end

    // AI-chosen moves.
    for (int k = 0; k < 8; k++) begin
      do_reset();
      repeat ($urandom_range(0, 5)) step(1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
      exp_mv = m_lfsr & 3;
      roll = (m_lfsr >> 2) & 15;
      exp_hit = (acc_tab[exp_mv] >= roll) ? 1 : 0;
      step(1'b0, 1'b1, 2'd0, 1'b1, 1'b0);
      chk("ai_move", bus.last_move, exp_mv);
      step(1'b0, 1'b1, 2'd0, 1'b0, 1'b0);
      chk("ai_new_hp", bus.new_hp, exp_hit ? 15 - dmg_tab[exp_mv] : 15);
    end

    // calc and apply on the same edge.
    do_reset();
    step(1'b1, 1'b0, 2'd0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 2'd0, 1'b1, 1'b1);
    chk("same_ai_hp", bus.AI_hp, 13);
    step(1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
    chk("same_new_hp", bus.new_hp, 13);

    // Apply one edge after calc writes the stale value.
    do_reset();
    step(1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 2'd1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
    chk("stale_p_hp", bus.p_hp, 13);

    // Reset mid-sequence, then an orphan apply writes zero.
    step(1'b1, 1'b0, 2'd0, 1'b1, 1'b0);
    do_reset();
    chk("mid_rst_p_hp", bus.p_hp, 15);
    chk("mid_rst_ai_hp", bus.AI_hp, 15);
    step(1'b1, 1'b0, 2'd0, 1'b0, 1'b1);
    chk("orphan_ai_hp", bus.AI_hp, 0);

    // Random traffic against the model.
    do_reset();
    for (int k = 0; k < 500; k++) begin
      rst = ($urandom_range(0, 59) == 0) ? 1'b0 : 1'b1;
      step(1'($urandom), 1'($urandom), 2'($urandom),
           1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pbs_battle_core.md
Name: pbs_battle_core

Overview:
- Battle datapath for the PBS turn-based game.
- Holds player and AI hit points. Selects the attacking move from the player input or a pseudo-random AI choice. Rolls accuracy and computes saturating damage.
- Merges the random source, the move table (damage/accuracy lookup) and the damage ALU into one block, driven cycle-by-cycle by the external battle FSM through calc_dmg/app_dmg strobes.

Parameters:
- SEED, 16'hACE1, reset value of the internal 16-bit LFSR; a value of 0 is replaced by 16'h0001.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  reset, synchronous, active-low.
- target  in  1  0 = player is defender, 1 = AI is defender.
- p_move  in  2  player's chosen move index.
- actr  in  1  attacker select: 0 = player (use p_move), 1 = AI (use random move).
- calc_dmg  in  1  strobe: latch move, defender HP and hit roll.
- app_dmg  in  1  strobe: write computed HP into defender register.
- p_hp  out  4  player hit points.
- AI_hp  out  4  AI hit points.
- new_hp  out  4  registered ALU result (pending HP).
- last_move  out  2  move index latched at last calc_dmg.
- last_hit  out  1  hit flag latched at last calc_dmg.
- rnd  out  6  current LFSR bits [5:0]: [1:0] = AI move, [5:2] = accuracy roll.

Behaviour:
- Reset (rst=0 at edge, priority over everything):
  - p_hp = AI_hp = 15.
  - new_hp, last_move and last_hit = 0.
  - Internal curr_hp and dmg registers = 0.
  - LFSR = SEED.
- Random source:
  - 16-bit Fibonacci LFSR, taps 16,14,13,11, shifts left every clk out of reset; never all-zero.
  - rng_ai = lfsr[1:0], rng_acc = lfsr[5:2].
- Move table (combinational), index -> damage, accuracy:
  - 0 -> 2, 15
  - 1 -> 4, 12
  - 2 -> 6, 8
  - 3 -> 9, 4
- Move select (combinational): mv = actr ? rng_ai : p_move.
- Stage 1, edge with calc_dmg=1:
  - last_move <= mv.
  - dmg <= damage(mv).
  - curr_hp <= target ? AI_hp : p_hp.
  - last_hit <= (accuracy(mv) >= rng_acc), unsigned 4-bit compare; move 0 always hits.
  - With calc_dmg=0 these registers hold.
- Stage 2, every edge: new_hp <= last_hit ? (curr_hp > dmg ? curr_hp - dmg : 0) : curr_hp.
  - new_hp is valid 2 edges after the calc_dmg edge and stays stable until the next calc_dmg.
- Apply, edge with app_dmg=1:
  - target=0: p_hp <= new_hp.
  - target=1: AI_hp <= new_hp.
  - Only the selected register changes.
- Latency: calc_dmg at edge N, app_dmg valid at edge N+2 or later. app_dmg at N+1 writes the previous new_hp; the controller is responsible for the spacing.
- calc_dmg and app_dmg on the same edge:
  - The apply writes the old new_hp.
  - The calc latches the pre-write HP.
- target is sampled independently at calc and apply. A mismatch writes the other defender's HP with the computed value; no check is made.
- HP never underflows (saturates at 0) and never exceeds 15; there is no healing.
- Reset asserted mid-sequence aborts it; a later app_dmg writes 0 unless a new calc occurs.

Test Plan:
- Reset with rst=0 for one edge -> p_hp=15, AI_hp=15, new_hp=0, rnd=SEED[5:0] after release.
- actr=0, p_move=0, target=1, calc_dmg at edge N, app_dmg at N+2 -> last_hit=1, new_hp=13, AI_hp=13, p_hp=15.
- Repeat move 0 on the player (target=0) eight times -> p_hp sequence 13,11,9,7,5,3,1,0, then stays 0 (saturation).
- actr=0, p_move=3, target=1 -> last_hit equals (rnd[5:2] at calc edge <= 4); AI_hp = 6 on hit (from 15), unchanged on miss; checked against a reference LFSR model.
- actr=1 with several calcs -> last_move equals rnd[1:0] at each calc edge; damage matches the table.
- calc_dmg and app_dmg on the same edge, and app_dmg at N+1 -> the stale new_hp is written; rst=0 mid-sequence -> both HP=15.
